// File: rtl/rx_frame_sync.sv
// Receive deframer: hunts a sync word with Hamming tolerance, resolves BPSK polarity, packs payload MSB-first into bytes.
// Byte strobe one cycle after the last bit's strobe; no backpressure, bits with bit_vld low are ignored.
module rx_frame_sync #(
  parameter logic [15:0] SYNC_WORD     = 16'hEB90,
  parameter int          SYNC_LEN      = 16,
  parameter int          PAYLOAD_BYTES = 16,
  parameter int          HUNT_ERR      = 1,
  parameter int          LOCK_ERR      = 3
) (
  input  logic        clk_16M384,
  input  logic        rst_16M384,
  input  logic        bit_in,
  input  logic        bit_vld,
  output logic [7:0]  data_tdata,
  output logic        data_tvalid,
  output logic        data_tuser,
  output logic        data_tlast,
  output logic        locked,
  output logic        inverted,
  output logic        sync_lost,
  output logic [15:0] frame_cnt
);

  localparam logic [4:0] HUNT_LIM  = 5'(HUNT_ERR);
  localparam logic [4:0] LOCK_LIM  = 5'(LOCK_ERR);
  localparam logic [3:0] SYNC_LAST = 4'(SYNC_LEN - 1);
  localparam logic [7:0] LAST_IDX  = 8'(PAYLOAD_BYTES - 1);

  typedef enum logic [1:0] {S_HUNT, S_PAYLOAD, S_CHECK} state_t;

  state_t      r_state;
  logic [14:0] r_sr;
  logic [6:0]  r_acc;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_byte_cnt;
  logic [7:0]  r_tdata;
  logic        r_tvalid, r_tuser, r_tlast, r_locked, r_inverted, r_sync_lost;
  logic [15:0] r_frame_cnt;

  logic [15:0] w_c;
  logic [7:0]  w_byte;
  logic [4:0]  w_dn, w_di, w_dchk;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s = s + {4'b0, v[i]};
    return s;
  endfunction

  // Candidate word includes the bit arriving this cycle, so a match is seen on its last bit.
  assign w_c    = {r_sr, bit_in};
  assign w_byte = {r_acc, bit_in ^ r_inverted};
  assign w_dn   = popcount16(w_c ^ SYNC_WORD);
  assign w_di   = popcount16(w_c ^ ~SYNC_WORD);
  assign w_dchk = r_inverted ? w_di : w_dn;

  always_ff @(posedge clk_16M384) begin
    if (rst_16M384) begin
      r_state     <= S_HUNT;
      r_sr        <= '0;
      r_acc       <= '0;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tuser     <= 1'b0;
      r_tlast     <= 1'b0;
      r_locked    <= 1'b0;
      r_inverted  <= 1'b0;
      r_sync_lost <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_tvalid    <= 1'b0;
      r_tuser     <= 1'b0;
      r_tlast     <= 1'b0;
      r_sync_lost <= 1'b0;
      if (bit_vld) begin
        r_sr <= w_c[14:0];
        case (r_state)
          S_HUNT: begin
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            if (w_dn <= HUNT_LIM) begin
              r_inverted <= 1'b0;
              r_state    <= S_PAYLOAD;
            end else if (w_di <= HUNT_LIM) begin
              r_inverted <= 1'b1;
              r_state    <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            r_acc <= w_byte[6:0];
            if (r_bit_cnt == 4'd7) begin
              r_bit_cnt <= '0;
              r_tdata   <= w_byte;
              r_tvalid  <= 1'b1;
              r_tuser   <= (r_byte_cnt == 8'd0);
              r_tlast   <= (r_byte_cnt == LAST_IDX);
              if (r_byte_cnt == LAST_IDX) begin
                r_byte_cnt  <= '0;
                r_frame_cnt <= r_frame_cnt + 16'd1;
                r_locked    <= 1'b1;
                r_state     <= S_CHECK;
              end else begin
                r_byte_cnt <= r_byte_cnt + 8'd1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          S_CHECK: begin
            if (r_bit_cnt == SYNC_LAST) begin
              r_bit_cnt <= '0;
              if (w_dchk <= LOCK_LIM) begin
                r_state <= S_PAYLOAD;
              end else begin
                r_sync_lost <= 1'b1;
                r_locked    <= 1'b0;
                r_state     <= S_HUNT;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          default: r_state <= S_HUNT;
        endcase
      end
    end
  end

  assign data_tdata  = r_tdata;
  assign data_tvalid = r_tvalid;
  assign data_tuser  = r_tuser;
  assign data_tlast  = r_tlast;
  assign locked      = r_locked;
  assign inverted    = r_inverted;
  assign sync_lost   = r_sync_lost;
  assign frame_cnt   = r_frame_cnt;

endmodule
